// File: rtl/aes_serial_stub_pkg.sv
// Shared encodings and sizing for the byte-serial AES stand-in.
package aes_serial_stub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ABSORB = 2'b01,
        ST_WAIT   = 2'b10,
        ST_EMIT   = 2'b11
    } state_e;

    localparam int NUM_BYTES = 16;
    localparam logic [3:0] LAST_BYTE = 4'd15;

    function automatic int byte_w(input int n);
        return 8 * (n + 1);
    endfunction

endpackage

// File: rtl/aes_stub_bytebuf.sv
// 16-entry share-wide register file, one write port, one async read port.
module aes_stub_bytebuf
    import aes_serial_stub_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         ClkxCI,
    input  logic         RstxBI,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [3:0]   raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem_q [NUM_BYTES];

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/aes_serial_stub.sv
// Byte-serial masked AES stand-in: absorbs 16 bytes, waits, emits PT^K.
module aes_serial_stub
    import aes_serial_stub_pkg::*;
#(
    parameter int N       = 1,
    parameter int LATENCY = 4
) (
    input  logic                 ClkxCI,
    input  logic                 RstxBI,
    input  logic                 StartxSI,
    input  logic [8*(N+1)-1:0]   PTxDI,
    input  logic [8*(N+1)-1:0]   KxDI,
    output logic                 DonexSO,
    output logic [8*(N+1)-1:0]   CxDO
);

    localparam int W = byte_w(N);
    localparam logic [7:0] WAIT_INIT = 8'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("aes_serial_stub: LATENCY must be in 1..255");
    end

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] wait_q, wait_d;
    logic       we;
    logic [W-1:0] rdata;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (StartxSI) begin
                    state_d = ST_ABSORB;
                    cnt_d   = '0;
                end
            end
            ST_ABSORB: begin
                we    = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_BYTE) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_INIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == 8'd0) begin
                    state_d = ST_EMIT;
                    cnt_d   = '0;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
            end
            ST_EMIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_BYTE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // XOR per share keeps every share independent of the others
    aes_stub_bytebuf #(
        .W(W)
    ) u_buf (
        .ClkxCI (ClkxCI),
        .RstxBI (RstxBI),
        .we     (we),
        .waddr  (cnt_q),
        .wdata  (PTxDI ^ KxDI),
        .raddr  (cnt_q),
        .rdata  (rdata)
    );

    assign DonexSO = (state_q == ST_EMIT) && (cnt_q == 4'd0);
    assign CxDO    = (state_q == ST_EMIT) ? rdata : '0;

endmodule

// File: doc/aes_serial_stub.md
# aes_serial_stub

Protocol-compatible stand-in for the byte-serial masked AES core, sitting where the core sits under the 128-bit load/compute/store wrapper. It absorbs 16 share-organized plaintext and key bytes after a start pulse, waits a programmable latency, then signals done and returns 16 "ciphertext" bytes on consecutive cycles. Each ciphertext share is the XOR of the plaintext share and the key share, which is linear and keeps the masking intact. The stub lets the wrapper's sequencing, byte ordering and capture windows be checked in simulation and formally without the full S-box pipeline.

## Interface
- N, default 1: masking order; each byte is carried as N+1 shares, 8*(N+1) bits wide.
- LATENCY, default 4: number of WAIT cycles between the last absorbed byte and the done/first output byte. Legal range is 1..255; elaboration fails outside that range.
- ClkxCI, input, 1: clock; all state changes on the rising edge.
- RstxBI, input, 1: asynchronous, active-low reset.
- StartxSI, input, 1: start request. It is sampled only in IDLE.
- PTxDI, input, 8*(N+1): plaintext byte, all shares, organized (A,B) share pairs from the top down.
- KxDI, input, 8*(N+1): key byte, same organization as PTxDI.
- DonexSO, output, 1: one-cycle pulse, concurrent with output byte 0. Reset value 0.
- CxDO, output, 8*(N+1): ciphertext byte. It is valid only during EMIT and forced to 0 otherwise. Reset value 0.

## Operation
- State register has four states: IDLE, ABSORB, WAIT, EMIT. There is also a 4-bit byte counter, an 8-bit wait counter, and a buffer of 16 entries of 8*(N+1) bits.
- IDLE: when StartxSI=1, go to ABSORB with byte counter 0. StartxSI in any other state is ignored, with no queuing and no restart.
- ABSORB: on each cycle, write buf[cnt] = PTxDI ^ KxDI (bitwise, share-wise) and increment cnt. At cnt==15, go to WAIT with wait counter = LATENCY-1 and cnt wrapping to 0.
- WAIT: decrement the wait counter. At 0, go to EMIT with cnt=0.
- EMIT: drive CxDO = buf[cnt] and increment cnt. DonexSO = 1 only when cnt==0. At cnt==15, go to IDLE.
- Byte order: byte i received on the i-th ABSORB cycle is returned on the i-th EMIT cycle. Byte 0 is the least significant byte of the 128-bit words.
- The buffer is not cleared between runs. The next run overwrites it entirely.
- Reset: asynchronous reset at any time, including mid-ABSORB or mid-EMIT. It forces IDLE, both counters to 0, buffer to 0, DonexSO=0 and CxDO=0 immediately. Operation restarts only on a new StartxSI after reset is released.

## Timing
- Start sampled high in IDLE at cycle T.
- Byte i is sampled at cycle T+1+i, for i = 0..15.
- WAIT occupies cycles T+17 .. T+16+LATENCY.
- DonexSO=1 and CxDO=byte 0 at cycle T+17+LATENCY. Byte i is output at T+17+LATENCY+i.
- IDLE is reached at T+33+LATENCY. The earliest next accepted start is that cycle.
- Total start-to-last-byte latency is 32+LATENCY cycles.
- Outputs are registered-state decodes. CxDO is a mux of the buffer by counter, gated by (state==EMIT). There is no combinational path from any input to any output.

## Structure
- Shared package holds the state encoding (IDLE=2'b00, ABSORB=2'b01, WAIT=2'b10, EMIT=2'b11), the byte count constant (16), and the byte width function 8*(N+1).
- One sub-module, aes_stub_bytebuf: a 16-entry, 8*(N+1)-bit register file. It has one write port (we, waddr, wdata), one asynchronous read port, and async active-low clear.
- The FSM and counters live in the top module.

## Test plan
- Single run, N=1, LATENCY=4: start at T, with byte i driven as PT=16'h0101*i and K=16'hA5A5. Required: DonexSO high exactly at T+21 only. CxDO at T+21+i equals (16'h0101*i)^16'hA5A5. CxDO is 0 outside T+21..T+36.
- Masking preservation: random shares whose share-XOR equals FIPS-197 byte pt ^ key. Required: the output shares XOR to pt^key for every byte, and each output share equals the matching input-share XOR.
- Start held high through an entire run. Required: exactly one run. IDLE is re-entered at T+37 and a second run starts at T+37, with DonexSO again at T+58.
- Reset asserted at T+8 (mid-ABSORB), released at T+10. Required: DonexSO=0 and CxDO=0 immediately and for all following cycles until a new start. The next run's outputs contain no stale bytes.
- LATENCY=1 boundary: required DonexSO at T+18. LATENCY=255: required DonexSO at T+272.
- Integration with the 128-bit wrapper, N=1: KxDI=0, PTxDI=128'h00112233…. Required: the wrapper's ciphertext output equals PTxDI one cycle before its done pulse, with all 16 bytes in order.
